// File: rtl/mem2wb_skid_stage.sv
// MEM->WB pipeline register with a 2-entry skid buffer, valid/ready handshake and flush.
// in_ready comes from registered state and flush only, so MEM never sees a path from out_ready.
module mem2wb_skid_stage #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 5,
    parameter int          MTR_W    = 2,
    parameter logic [31:0] PC_RESET = 32'h80000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_regwr,
    input  logic [ADDR_W-1:0] in_wraddr,
    input  logic [MTR_W-1:0]  in_memtoreg,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_aluout,
    input  logic [DATA_W-1:0] in_rddata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_regwr,
    output logic [ADDR_W-1:0] out_wraddr,
    output logic [MTR_W-1:0]  out_memtoreg,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_aluout,
    output logic [DATA_W-1:0] out_rddata,
    output logic [1:0]        occupancy
);

    logic              m_valid_q, m_valid_d;
    logic              m_regwr_q, m_regwr_d;
    logic [ADDR_W-1:0] m_wraddr_q, m_wraddr_d;
    logic [MTR_W-1:0]  m_memtoreg_q, m_memtoreg_d;
    logic [DATA_W-1:0] m_pc_q, m_pc_d;
    logic [DATA_W-1:0] m_aluout_q, m_aluout_d;
    logic [DATA_W-1:0] m_rddata_q, m_rddata_d;

    logic              s_valid_q, s_valid_d;
    logic              s_regwr_q, s_regwr_d;
    logic [ADDR_W-1:0] s_wraddr_q, s_wraddr_d;
    logic [MTR_W-1:0]  s_memtoreg_q, s_memtoreg_d;
    logic [DATA_W-1:0] s_pc_q, s_pc_d;
    logic [DATA_W-1:0] s_aluout_q, s_aluout_d;
    logic [DATA_W-1:0] s_rddata_q, s_rddata_d;

    logic [1:0]        occupancy_q, occupancy_d;
    logic              accept;
    logic              drain;

    assign in_ready = ~s_valid_q & ~flush;
    assign accept   = in_valid & in_ready;
    assign drain    = m_valid_q & out_ready;

    always_comb begin
        m_valid_d    = m_valid_q;
        m_regwr_d    = m_regwr_q;
        m_wraddr_d   = m_wraddr_q;
        m_memtoreg_d = m_memtoreg_q;
        m_pc_d       = m_pc_q;
        m_aluout_d   = m_aluout_q;
        m_rddata_d   = m_rddata_q;
        s_valid_d    = s_valid_q;
        s_regwr_d    = s_regwr_q;
        s_wraddr_d   = s_wraddr_q;
        s_memtoreg_d = s_memtoreg_q;
        s_pc_d       = s_pc_q;
        s_aluout_d   = s_aluout_q;
        s_rddata_d   = s_rddata_q;

        // Empty M always carries zeroed write controls so a bubble can never write the RF.
        if (flush) begin
            m_valid_d    = 1'b0;
            s_valid_d    = 1'b0;
            m_regwr_d    = 1'b0;
            m_wraddr_d   = '0;
            m_memtoreg_d = '0;
        end else if (!m_valid_q || drain) begin
            if (s_valid_q) begin
                m_valid_d    = 1'b1;
                m_regwr_d    = s_regwr_q;
                m_wraddr_d   = s_wraddr_q;
                m_memtoreg_d = s_memtoreg_q;
                m_pc_d       = s_pc_q;
                m_aluout_d   = s_aluout_q;
                m_rddata_d   = s_rddata_q;
                s_valid_d    = 1'b0;
            end else if (accept) begin
                m_valid_d    = 1'b1;
                m_regwr_d    = in_regwr;
                m_wraddr_d   = in_wraddr;
                m_memtoreg_d = in_memtoreg;
                m_pc_d       = in_pc;
                m_aluout_d   = in_aluout;
                m_rddata_d   = in_rddata;
            end else begin
                m_valid_d    = 1'b0;
                m_regwr_d    = 1'b0;
                m_wraddr_d   = '0;
                m_memtoreg_d = '0;
            end
        end else if (accept) begin
            s_valid_d    = 1'b1;
            s_regwr_d    = in_regwr;
            s_wraddr_d   = in_wraddr;
            s_memtoreg_d = in_memtoreg;
            s_pc_d       = in_pc;
            s_aluout_d   = in_aluout;
            s_rddata_d   = in_rddata;
        end

        occupancy_d = {1'b0, m_valid_d} + {1'b0, s_valid_d};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid_q    <= 1'b0;
            m_regwr_q    <= 1'b0;
            m_wraddr_q   <= '0;
            m_memtoreg_q <= '0;
            m_pc_q       <= DATA_W'(PC_RESET);
            m_aluout_q   <= '0;
            m_rddata_q   <= '0;
            s_valid_q    <= 1'b0;
            s_regwr_q    <= 1'b0;
            s_wraddr_q   <= '0;
            s_memtoreg_q <= '0;
            s_pc_q       <= '0;
            s_aluout_q   <= '0;
            s_rddata_q   <= '0;
            occupancy_q  <= 2'd0;
        end else begin
            m_valid_q    <= m_valid_d;
            m_regwr_q    <= m_regwr_d;
            m_wraddr_q   <= m_wraddr_d;
            m_memtoreg_q <= m_memtoreg_d;
            m_pc_q       <= m_pc_d;
            m_aluout_q   <= m_aluout_d;
            m_rddata_q   <= m_rddata_d;
            s_valid_q    <= s_valid_d;
            s_regwr_q    <= s_regwr_d;
            s_wraddr_q   <= s_wraddr_d;
            s_memtoreg_q <= s_memtoreg_d;
            s_pc_q       <= s_pc_d;
            s_aluout_q   <= s_aluout_d;
            s_rddata_q   <= s_rddata_d;
            occupancy_q  <= occupancy_d;
        end
    end

    assign out_valid    = m_valid_q;
    assign out_regwr    = m_regwr_q;
    assign out_wraddr   = m_wraddr_q;
    assign out_memtoreg = m_memtoreg_q;
    assign out_pc       = m_pc_q;
    assign out_aluout   = m_aluout_q;
    assign out_rddata   = m_rddata_q;
    assign occupancy    = occupancy_q;

endmodule

// File: tb/tb_mem2wb_skid_stage.sv
// Self-checking bench for mem2wb_skid_stage: directed scenarios then a randomized run,
// all compared against a 2-deep FIFO reference model of the stage.
module tb_mem2wb_skid_stage;

    typedef struct {
        logic        regwr;
        logic [4:0]  wraddr;
        logic [1:0]  mtr;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rd;
    } bundle_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_regwr = 1'b0;
    logic [4:0]  in_wraddr = '0;
    logic [1:0]  in_memtoreg = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_aluout = '0;
    logic [31:0] in_rddata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_regwr;
    logic [4:0]  out_wraddr;
    logic [1:0]  out_memtoreg;
    logic [31:0] out_pc;
    logic [31:0] out_aluout;
    logic [31:0] out_rddata;
    logic [1:0]  occupancy;

    int checks = 0;
    int failures = 0;
    int delivered = 0;
    bundle_t q[$];
    bundle_t holdB;
    bundle_t resetB;

    mem2wb_skid_stage #(
        .DATA_W(32), .ADDR_W(5), .MTR_W(2), .PC_RESET(32'h80000000)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_regwr(in_regwr), .in_wraddr(in_wraddr), .in_memtoreg(in_memtoreg),
        .in_pc(in_pc), .in_aluout(in_aluout), .in_rddata(in_rddata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_regwr(out_regwr), .out_wraddr(out_wraddr), .out_memtoreg(out_memtoreg),
        .out_pc(out_pc), .out_aluout(out_aluout), .out_rddata(out_rddata),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output with the model: the FIFO head when non-empty, held data otherwise.
    task automatic checkOutput();
        bundle_t e;
        check("in_ready", 32'(in_ready), 32'((q.size() < 2) && !flush));
        check("occupancy", 32'(occupancy), 32'(q.size()));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) e = q[0];
        else begin
            e = holdB;
            e.regwr = 1'b0;
            e.wraddr = '0;
            e.mtr = '0;
        end
        check("out_regwr", 32'(out_regwr), 32'(e.regwr));
        check("out_wraddr", 32'(out_wraddr), 32'(e.wraddr));
        check("out_memtoreg", 32'(out_memtoreg), 32'(e.mtr));
        check("out_pc", out_pc, e.pc);
        check("out_aluout", out_aluout, e.alu);
        check("out_rddata", out_rddata, e.rd);
    endtask

    task automatic applyStimulus(input logic v, input logic r, input logic fl, input bundle_t b);
        logic acc, drn;
        in_valid = v;
        out_ready = r;
        flush = fl;
        in_regwr = b.regwr;
        in_wraddr = b.wraddr;
        in_memtoreg = b.mtr;
        in_pc = b.pc;
        in_aluout = b.alu;
        in_rddata = b.rd;
        #1;
        checkOutput();
        acc = v && (q.size() < 2) && !fl;
        drn = (q.size() > 0) && r;
        @(posedge clk);
        #1;
        if (drn) begin
            void'(q.pop_front());
            delivered++;
        end
        if (fl) q.delete();
        else if (acc) q.push_back(b);
        if (q.size() > 0) holdB = q[0];
    endtask

    function automatic bundle_t randB();
        bundle_t b;
        b.regwr = ($urandom_range(0, 3) != 0);
        b.wraddr = 5'($urandom);
        b.mtr = 2'($urandom);
        b.pc = $urandom;
        b.alu = $urandom;
        b.rd = $urandom;
        return b;
    endfunction

    function automatic bundle_t mkB(input logic [31:0] pc, input logic [4:0] wa);
        bundle_t b;
        b.regwr = 1'b1;
        b.wraddr = wa;
        b.mtr = 2'(wa);
        b.pc = pc;
        b.alu = pc ^ 32'h00ff00ff;
        b.rd = ~pc;
        return b;
    endfunction

    initial begin
        bundle_t idle;
        resetB = '{regwr: 1'b0, wraddr: '0, mtr: '0, pc: 32'h80000000, alu: '0, rd: '0};
        holdB = resetB;
        idle = resetB;

        // Reset state, observed while reset is held and after release.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_pc", out_pc, 32'h80000000);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        checkOutput();

        // Back-to-back stream with out_ready high.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b1, 1'b0, mkB(32'h80000000 + 32'(4 * i), 5'(i + 1)));
        applyStimulus(1'b0, 1'b1, 1'b0, idle);
        applyStimulus(1'b0, 1'b1, 1'b0, idle);

        // Stall: fill both entries, then drain.
        applyStimulus(1'b1, 1'b0, 1'b0, mkB(32'h100, 5'd10));
        applyStimulus(1'b1, 1'b0, 1'b0, mkB(32'h104, 5'd11));
        applyStimulus(1'b1, 1'b0, 1'b0, mkB(32'h108, 5'd12));
        check("full_occupancy", 32'(occupancy), 32'd2);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, idle);

        // Flush while full with in_valid high; flush-cycle input must be dropped.
        applyStimulus(1'b1, 1'b0, 1'b0, mkB(32'h200, 5'd20));
        applyStimulus(1'b1, 1'b0, 1'b0, mkB(32'h204, 5'd21));
        applyStimulus(1'b1, 1'b0, 1'b1, mkB(32'h208, 5'd22));
        check("flush_occupancy", 32'(occupancy), 32'd0);
        check("flush_wraddr", 32'(out_wraddr), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, idle);

        // Flush together with a drain.
        applyStimulus(1'b1, 1'b1, 1'b0, mkB(32'h300, 5'd7));
        applyStimulus(1'b0, 1'b1, 1'b1, idle);
        applyStimulus(1'b0, 1'b1, 1'b0, idle);

        // Asynchronous reset between edges while full.
        applyStimulus(1'b1, 1'b0, 1'b0, mkB(32'h400, 5'd3));
        applyStimulus(1'b1, 1'b0, 1'b0, mkB(32'h404, 5'd4));
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        holdB = resetB;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_out_pc", out_pc, 32'h80000000);
        checkOutput();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b0, mkB(32'h500, 5'd9));
        check("post_rst_latency", 32'(out_valid), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, idle);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 10000; i++)
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 63) == 0), randB());

        $display("[TB] delivered %0d bundles", delivered);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
